// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the two-master bus arbiter and its hold counter.
package bus_arbiter_pkg;

   localparam int unsigned BUS_ADDR_W   = 8;
   localparam int unsigned BUS_DATA_W   = 32;
   localparam int unsigned BUS_MAX_HOLD = 16;

   typedef enum logic {
      M0_GRANT = 1'b0,
      M1_GRANT = 1'b1
   } bus_state_e;

endpackage

// File: rtl/bus_hold_cnt.sv
// Contention hold counter: counts consecutive contended cycles and flags the last allowed one.
module bus_hold_cnt
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = BUS_MAX_HOLD
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Saturating count; clear wins over enable.
   always_comb begin
      cnt_nxt = cnt;
      if (clear) begin
         cnt_nxt = '0;
      end else if (enable && (cnt != LAST)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   // expire is kept as a flop alongside the count so it has no decode path.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         expire <= (LAST == '0);
      end else begin
         cnt    <= cnt_nxt;
         expire <= (cnt_nxt == LAST);
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter, master 0 priority, parks on master 0.
// Optional contention timeout enabled by defining BUS_HOLD_TIMEOUT_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W   = BUS_ADDR_W,
   parameter int unsigned DATA_W   = BUS_DATA_W,
   parameter int unsigned MAX_HOLD = BUS_MAX_HOLD
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              M0_req,
   input  logic              M0_wr,
   input  logic [ADDR_W-1:0] M0_addr,
   input  logic [DATA_W-1:0] M0_dout,
   input  logic              M1_req,
   input  logic              M1_wr,
   input  logic [ADDR_W-1:0] M1_addr,
   input  logic [DATA_W-1:0] M1_dout,
   output logic              M0_grant,
   output logic              M1_grant,
   output logic              S_req,
   output logic              S_wr,
   output logic [ADDR_W-1:0] S_addr,
   output logic [DATA_W-1:0] S_din
);

   if (MAX_HOLD == 0) begin : g_bad_max_hold
      $error("bus_arbiter: MAX_HOLD must be at least 1");
   end

   bus_state_e state;
   bus_state_e state_nxt;

`ifdef BUS_HOLD_TIMEOUT_EN
   logic other_req_c;
   logic hold_expire;
   logic hold_clear;

   assign other_req_c = (state == M0_GRANT) ? M1_req : M0_req;
   assign hold_clear  = (state_nxt != state) || !other_req_c;

   bus_hold_cnt #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (hold_clear),
      .enable  (other_req_c),
      .expire  (hold_expire)
   );
`endif

   // Next-state: owner keeps the bus until it releases; master 0 wins ties.
   always_comb begin
      state_nxt = state;
      case (state)
         M0_GRANT: if (!M0_req && M1_req) state_nxt = M1_GRANT;
         M1_GRANT: if (!M1_req)           state_nxt = M0_GRANT;
         default:                         state_nxt = M0_GRANT;
      endcase
`ifdef BUS_HOLD_TIMEOUT_EN
      if (hold_expire && other_req_c) begin
         state_nxt = (state == M0_GRANT) ? M1_GRANT : M0_GRANT;
      end
`endif
   end

   // Grants are flopped next to the state so they never see the requests combinationally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= M0_GRANT;
         M0_grant <= 1'b1;
         M1_grant <= 1'b0;
      end else begin
         state    <= state_nxt;
         M0_grant <= (state_nxt == M0_GRANT);
         M1_grant <= (state_nxt == M1_GRANT);
      end
   end

   // Slave-side mux: only the owner's signals pass through.
   always_comb begin
      S_req  = M0_req;
      S_wr   = M0_wr;
      S_addr = M0_addr;
      S_din  = M0_dout;
      if (state == M1_GRANT) begin
         S_req  = M1_req;
         S_wr   = M1_wr;
         S_addr = M1_addr;
         S_din  = M1_dout;
      end
   end

endmodule
